// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU:
// opcodes, FSM states and the default datapath width.
package alu_pkg;

  localparam int DEF_WIDTH = 64;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: one result, zero flag and
// an error flag for unsupported opcodes.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_PASSB: result = b;
      ALU_NOR:   result = ~(a | b);
      default: begin
        result = '0;
        err    = 1'b1;
      end
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU
// between N_REQ requesters, one transaction in flight.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_REQ = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [4*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   rsp_zero,
  output logic                   rsp_err,
  output logic                   busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t state, state_nx;

  logic [IW-1:0]    gnt_idx, last_idx, win;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic             zero_q, err_q;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero, alu_err;
  logic             any, accept, done;

  // Smallest offset from last wins; scanning
  // backwards lets the nearest valid overwrite.
  function automatic logic [IW-1:0] rr_pick(
    input logic [N_REQ-1:0] v,
    input logic [IW-1:0]    last
  );
    logic [IW-1:0] w;
    int            j;
    w = last;
    for (int k = N_REQ; k >= 1; k--) begin
      j = (int'(last) + k) % N_REQ;
      if (v[j]) w = IW'(j);
    end
    return w;
  endfunction

  assign win    = rr_pick(req_valid, last_idx);
  assign any    = |req_valid;
  assign accept = (state == IDLE) && any;
  assign done   = (state == RESP) && rsp_ready[gnt_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = (state != IDLE);
    if (accept)         req_ready[win]     = 1'b1;
    if (state == RESP)  rsp_valid[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_idx  <= '0;
      last_idx <= IW'(N_REQ - 1);
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        gnt_idx <= win;
        op_q    <= req_op[int'(win)*4 +: 4];
        a_q     <= req_a[int'(win)*WIDTH +: WIDTH];
        b_q     <= req_b[int'(win)*WIDTH +: WIDTH];
      end
      if (state == EXEC) begin
        result_q <= alu_res;
        zero_q   <= alu_zero;
        err_q    <= alu_err;
      end
      if (done) last_idx <= gnt_idx;
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_res),
    .zero   (alu_zero),
    .err    (alu_err)
  );

  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_alu_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [7:0]   req_op;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [63:0]  rsp_result;
  logic         rsp_zero;
  logic         rsp_err;
  logic         busy;

  int errors = 0;
  int checks = 0;

  logic [3:0] optab [8] = '{4'h0, 4'h1, 4'h2, 4'h6,
                            4'h7, 4'hC, 4'hF, 4'h5};

  alu_arbiter #(.WIDTH(64), .N_REQ(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // {err, result} straight from the opcode table
  function automatic logic [64:0] ref_alu(
    input logic [3:0] op,
    input logic [63:0] a,
    input logic [63:0] b
  );
    case (op)
      4'b0000: return {1'b0, a & b};
      4'b0001: return {1'b0, a | b};
      4'b0010: return {1'b0, a + b};
      4'b0110: return {1'b0, a - b};
      4'b0111: return {1'b0, b};
      4'b1100: return {1'b0, ~(a | b)};
      default: return {1'b1, 64'd0};
    endcase
  endfunction

  task automatic set_req(input int r, input logic [3:0] op,
                         input logic [63:0] a, input logic [63:0] b);
    req_op[4*r +: 4]  = op;
    req_a[64*r +: 64] = a;
    req_b[64*r +: 64] = b;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] vm, output logic [1:0] rdy,
                       output int lat, output logic [1:0] rv,
                       output logic [63:0] res, output logic z,
                       output logic e, output bit to);
    rdy = '0; lat = 0; rv = '0; res = '0;
    z = 1'b0; e = 1'b0; to = 1'b0;
    req_valid = vm;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      if (rdy != 2'b00) break;
    end
    #1 req_valid = '0;
    if (rdy == 2'b00) begin
      to = 1'b1;
      return;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid != 2'b00) begin
        rv = rsp_valid; res = rsp_result;
        z = rsp_zero; e = rsp_err;
        break;
      end
    end
    if (rv == 2'b00) to = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 2'b11;
    req_op = '0; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rsp_valid, req_ready, busy, rsp_zero, rsp_err} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=0",
               {rsp_valid, req_ready, busy, rsp_zero, rsp_err});
    end
    checks++;
    if (rsp_result !== 64'd0) begin
      errors++;
      $display("FAIL reset_result got=%h exp=0", rsp_result);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    logic [1:0] rdy, rv; int lat; logic [63:0] res;
    logic z, e; bit to;
    set_req(0, 4'b0010, 64'd5, 64'd7);
    drive(2'b01, rdy, lat, rv, res, z, e, to);
    checks++;
    if (to || rdy !== 2'b01 || rv !== 2'b01 || lat != 2) begin
      errors++;
      $display("FAIL add_hs got rdy=%b rv=%b lat=%0d to=%0d exp 01/01/2/0",
               rdy, rv, lat, to);
    end
    checks++;
    if ({e, z, res} !== {1'b0, 1'b0, 64'd12}) begin
      errors++;
      $display("FAIL add_result got=%h z=%b e=%b exp=c z=0 e=0", res, z, e);
    end
  endtask

  task automatic test_sub();
    logic [1:0] rdy, rv; int lat; logic [63:0] res;
    logic z, e; bit to;
    set_req(0, 4'b0110, 64'd3, 64'd3);
    drive(2'b01, rdy, lat, rv, res, z, e, to);
    checks++;
    if (to || {res, z, e} !== {64'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sub_zero got=%h z=%b e=%b to=%0d exp=0 z=1 e=0",
               res, z, e, to);
    end
    set_req(0, 4'b0110, 64'd0, 64'd1);
    drive(2'b01, rdy, lat, rv, res, z, e, to);
    checks++;
    if (to || {res, z, e} !== {64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_wrap got=%h z=%b e=%b to=%0d exp=all-ones z=0",
               res, z, e, to);
    end
  endtask

  task automatic test_alternate();
    int gq[$]; logic [63:0] rq[$]; logic [1:0] vq[$];
    logic [63:0] exp_r;
    do_reset();
    set_req(0, 4'b0000, 64'hF0, 64'h3C);
    set_req(1, 4'b0001, 64'hF0, 64'h3C);
    req_valid = 2'b11;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00) gq.push_back(req_ready[1] ? 1 : 0);
      if (rsp_valid != 2'b00) begin
        vq.push_back(rsp_valid);
        rq.push_back(rsp_result);
      end
    end
    @(posedge clk);
    #1 req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (gq.size() < 4 || rq.size() < 4) begin
      errors++;
      $display("FAIL rr_count got grants=%0d rsps=%0d exp>=4",
               gq.size(), rq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp_r = (i % 2 == 0) ? 64'h30 : 64'hFC;
        checks++;
        if (gq[i] != i % 2 || vq[i] !== 2'(1 << (i % 2)) ||
            rq[i] !== exp_r) begin
          errors++;
          $display("FAIL rr_seq%0d got g=%0d v=%b r=%h exp g=%0d r=%h",
                   i, gq[i], vq[i], rq[i], i % 2, exp_r);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_r;
    bit seen;
    do_reset();
    rsp_ready = 2'b10;
    set_req(0, 4'b0010, 64'h100, 64'h23);
    set_req(1, 4'b0001, 64'h5, 64'hA0);
    exp_r = ref_alu(4'b0010, 64'h100, 64'h23);
    req_valid = 2'b01;
    @(posedge clk);
    #1 req_valid = 2'b10;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = (rsp_valid != 2'b00);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_rsp got=timeout exp=rsp_valid");
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (rsp_valid !== 2'b01 || rsp_result !== exp_r ||
          busy !== 1'b1 || req_ready !== 2'b00) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b r=%h busy=%b rdy=%b exp 01/%h/1/00",
                 c, rsp_valid, rsp_result, busy, req_ready, exp_r);
      end
      @(negedge clk);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_next got rdy=%b busy=%b exp 10/0", req_ready, busy);
    end
    rsp_ready = 2'b11;
    @(posedge clk);
    #1 req_valid = '0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = (rsp_valid != 2'b00);
    end
    checks++;
    if (rsp_valid !== 2'b10 || rsp_result !== 64'hA5) begin
      errors++;
      $display("FAIL bp_second got v=%b r=%h exp 10/a5", rsp_valid, rsp_result);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ops();
    logic [1:0] rdy, rv; int lat; logic [63:0] res;
    logic z, e; bit to;
    set_req(0, 4'b1111, 64'd9, 64'd9);
    drive(2'b01, rdy, lat, rv, res, z, e, to);
    checks++;
    if (to || {res, z, e} !== {64'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL op_err got=%h z=%b e=%b exp=0 z=1 e=1", res, z, e);
    end
    set_req(0, 4'b0111, 64'h1234, 64'hABCD);
    drive(2'b01, rdy, lat, rv, res, z, e, to);
    checks++;
    if (to || {res, z, e} !== {64'hABCD, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL op_passb got=%h z=%b e=%b exp=abcd", res, z, e);
    end
    set_req(0, 4'b1100, 64'd0, 64'd0);
    drive(2'b01, rdy, lat, rv, res, z, e, to);
    checks++;
    if (to || {res, z, e} !== {64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL op_nor got=%h z=%b e=%b exp=all-ones", res, z, e);
    end
  endtask

  task automatic test_random();
    logic [1:0] rdy, rv, vm; int lat; logic [63:0] res;
    logic z, e; bit to;
    int last_m, w;
    logic [64:0] m;
    do_reset();
    last_m = 1;
    for (int n = 0; n < 40; n++) begin
      for (int r = 0; r < 2; r++)
        set_req(r, optab[$urandom_range(7)], {$urandom, $urandom},
                (n % 5 == 0) ? req_a[64*r +: 64] : {$urandom, $urandom});
      vm = 2'($urandom_range(3, 1));
      w = -1;
      for (int k = 1; k <= 2 && w < 0; k++)
        if (vm[(last_m + k) % 2]) w = (last_m + k) % 2;
      m = ref_alu(req_op[4*w +: 4], req_a[64*w +: 64], req_b[64*w +: 64]);
      drive(vm, rdy, lat, rv, res, z, e, to);
      checks++;
      if (to || rdy !== 2'(1 << w) || rv !== 2'(1 << w) ||
          res !== m[63:0] || e !== m[64] || z !== (m[63:0] == 64'd0)) begin
        errors++;
        $display("FAIL rand%0d got rdy=%b rv=%b r=%h z=%b e=%b exp g=%0d r=%h e=%b",
                 n, rdy, rv, res, z, e, w, m[63:0], m[64]);
      end
      last_m = w;
      repeat ($urandom_range(2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    set_req(1, 4'b0010, 64'd1, 64'd2);
    set_req(0, 4'b0001, 64'd4, 64'd8);
    req_valid = 2'b10;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL mid_grant got=%b exp=10", req_ready);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_async got v=%b busy=%b exp 00/0", rsp_valid, busy);
    end
    req_valid = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL mid_prio got=%b exp=01", req_ready);
    end
    @(posedge clk);
    #1 req_valid = '0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = (rsp_valid != 2'b00);
    end
    checks++;
    if (rsp_valid !== 2'b01 || rsp_result !== 64'hC) begin
      errors++;
      $display("FAIL mid_rsp got v=%b r=%h exp 01/c", rsp_valid, rsp_result);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ops();
    test_alternate();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
